// File: rtl/kreg_arb_pkg.sv
// Shared types for the kreg_arb register-bank arbiter.
package kreg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic REQ_ID_A = 1'b0;
  localparam logic REQ_ID_B = 1'b1;

endpackage

// File: rtl/kreg_bank.sv
// Register bank with per-register load strobes, synchronous clear-all and async reset.
module kreg_bank #(
  parameter int NREG  = 8,
  parameter int WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    nCLEAR,
  input  logic [NREG-1:0]         i_load,
  input  logic                    i_clr,
  input  logic [WIDTH-1:0]        i_data,
  output logic [NREG*WIDTH-1:0]   o_regs
);

  logic [WIDTH-1:0] r_bank [NREG];

  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) begin
      for (int i = 0; i < NREG; i++) r_bank[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NREG; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_load[i]) r_bank[i] <= i_data;
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int i = 0; i < NREG; i++) o_regs[i*WIDTH +: WIDTH] = r_bank[i];
  end

endmodule

// File: rtl/kreg_arb.sv
// Two-requester write arbiter in front of kreg_bank.
// Define KREG_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority.
module kreg_arb
  import kreg_arb_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  CLK,
  input  logic                  nCLEAR,
  input  logic                  REQ_A,
  input  logic                  REQ_B,
  input  logic [AW-1:0]         ADDR_A,
  input  logic [AW-1:0]         ADDR_B,
  input  logic [WIDTH-1:0]      DATA_A,
  input  logic [WIDTH-1:0]      DATA_B,
  output logic                  ACK_A,
  output logic                  ACK_B,
  input  logic                  CLR_ALL,
  output logic                  BUSY,
  output logic [NREG*WIDTH-1:0] REGS
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_clr_pend;
  logic             w_grant;
  logic             w_clr;
  logic             w_win_id;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic [NREG-1:0]  w_load;

`ifdef KREG_ARB_RR_EN
  logic r_last_id;

  // Reset value B so the first tie goes to A.
  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR)      r_last_id <= REQ_ID_B;
    else if (w_grant) r_last_id <= w_win_id;
  end

  always_comb begin
    w_win_id = REQ_A ? REQ_ID_A : REQ_ID_B;
    if (REQ_A && REQ_B) w_win_id = (r_last_id == REQ_ID_A) ? REQ_ID_B : REQ_ID_A;
  end
`else
  always_comb begin
    w_win_id = REQ_A ? REQ_ID_A : REQ_ID_B;
  end
`endif

  assign w_addr = (w_win_id == REQ_ID_A) ? ADDR_A : ADDR_B;
  assign w_data = (w_win_id == REQ_ID_A) ? DATA_A : DATA_B;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (CLR_ALL || r_clr_pend) begin
          w_clr = 1'b1;
        end else if (REQ_A || REQ_B) begin
          w_grant     = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      WRITE:   w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_id    <= REQ_ID_A;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_id   <= w_win_id;
      end
    end
  end

  // A clear seen mid-transaction is remembered and wins the next IDLE cycle.
  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR)      r_clr_pend <= 1'b0;
    else if (w_clr)   r_clr_pend <= 1'b0;
    else if (CLR_ALL) r_clr_pend <= 1'b1;
  end

  always_comb begin
    w_load = '0;
    if (r_state == WRITE) w_load[r_addr] = 1'b1;
  end

  assign ACK_A = (r_state == ACK) && (r_id == REQ_ID_A);
  assign ACK_B = (r_state == ACK) && (r_id == REQ_ID_B);
  assign BUSY  = (r_state != IDLE);

  kreg_bank #(
    .NREG  (NREG),
    .WIDTH (WIDTH)
  ) u_bank (
    .CLK    (CLK),
    .nCLEAR (nCLEAR),
    .i_load (w_load),
    .i_clr  (w_clr),
    .i_data (r_data),
    .o_regs (REGS)
  );

endmodule

// File: tb/tb_kreg_arb.sv
// Directed self-checking bench for kreg_arb (NREG=8, WIDTH=8); honours KREG_ARB_RR_EN.
module tb_kreg_arb;

  logic        CLK;
  logic        nCLEAR;
  logic        REQ_A, REQ_B;
  logic [2:0]  ADDR_A, ADDR_B;
  logic [7:0]  DATA_A, DATA_B;
  logic        ACK_A, ACK_B;
  logic        CLR_ALL;
  logic        BUSY;
  logic [63:0] REGS;

  logic [63:0] exp_regs;
  int          checks;
  int          errors;

  kreg_arb #(.NREG(8), .WIDTH(8)) dut (
    .CLK     (CLK),
    .nCLEAR  (nCLEAR),
    .REQ_A   (REQ_A),
    .REQ_B   (REQ_B),
    .ADDR_A  (ADDR_A),
    .ADDR_B  (ADDR_B),
    .DATA_A  (DATA_A),
    .DATA_B  (DATA_B),
    .ACK_A   (ACK_A),
    .ACK_B   (ACK_B),
    .CLR_ALL (CLR_ALL),
    .BUSY    (BUSY),
    .REGS    (REGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nCLEAR = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; CLR_ALL = 1'b0;
    ADDR_A = '0; ADDR_B = '0; DATA_A = '0; DATA_B = '0;
    exp_regs = '0;
    #12;
    checks++;
    if (REGS !== 64'h0) begin errors++; $display("FAIL reset_regs got %h exp %h", REGS, 64'h0); end
    checks++;
    if ({BUSY, ACK_A, ACK_B} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {BUSY, ACK_A, ACK_B});
    end
    #1 nCLEAR = 1'b1;
    tick();
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", BUSY); end
  endtask

  task automatic test_single();
    REQ_A = 1'b1; ADDR_A = 3'd3; DATA_A = 8'h5A;
    tick();
    REQ_A = 1'b0;
    checks++;
    if ({BUSY, ACK_A, ACK_B} !== 3'b100 || REGS !== exp_regs) begin
      errors++; $display("FAIL single_write_cycle got busy/acks %b regs %h exp 100 regs %h",
                         {BUSY, ACK_A, ACK_B}, REGS, exp_regs);
    end
    tick();
    exp_regs[3*8 +: 8] = 8'h5A;
    checks++;
    if (REGS !== exp_regs) begin errors++; $display("FAIL single_regs got %h exp %h", REGS, exp_regs); end
    checks++;
    if ({BUSY, ACK_A, ACK_B} !== 3'b110) begin
      errors++; $display("FAIL single_ack got %b exp 110", {BUSY, ACK_A, ACK_B});
    end
    tick();
    checks++;
    if ({BUSY, ACK_A, ACK_B} !== 3'b000) begin
      errors++; $display("FAIL single_done got %b exp 000", {BUSY, ACK_A, ACK_B});
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_ack;
    int         grant_no;
    REQ_A = 1'b1; ADDR_A = 3'd1; DATA_A = 8'h11;
    REQ_B = 1'b1; ADDR_B = 3'd2; DATA_B = 8'h22;
    grant_no = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ack = 2'b00;
      if (k % 3 == 2) begin
`ifdef KREG_ARB_RR_EN
        exp_ack = (grant_no % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp_ack = 2'b10;
`endif
        grant_no++;
      end
      checks++;
      if ({ACK_A, ACK_B} !== exp_ack) begin
        errors++; $display("FAIL arb_ack_cycle%0d got %b exp %b", k, {ACK_A, ACK_B}, exp_ack);
      end
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    exp_regs[1*8 +: 8] = 8'h11;
`ifdef KREG_ARB_RR_EN
    exp_regs[2*8 +: 8] = 8'h22;
`endif
    checks++;
    if (REGS !== exp_regs) begin errors++; $display("FAIL arb_regs got %h exp %h", REGS, exp_regs); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL arb_idle busy got %b exp 0", BUSY); end
  endtask

  task automatic test_clr_during_write();
    REQ_A = 1'b1; ADDR_A = 3'd4; DATA_A = 8'hFF;
    tick();
    REQ_A = 1'b0; CLR_ALL = 1'b1;
    tick();
    CLR_ALL = 1'b0;
    exp_regs[4*8 +: 8] = 8'hFF;
    checks++;
    if (REGS !== exp_regs || ACK_A !== 1'b1) begin
      errors++; $display("FAIL clr_write got regs %h ack %b exp regs %h ack 1", REGS, ACK_A, exp_regs);
    end
    tick();
    checks++;
    if (REGS !== exp_regs || BUSY !== 1'b0) begin
      errors++; $display("FAIL clr_not_early got regs %h busy %b exp regs %h busy 0", REGS, BUSY, exp_regs);
    end
    REQ_B = 1'b1; ADDR_B = 3'd6; DATA_B = 8'h66;
    tick();
    exp_regs = '0;
    checks++;
    if (REGS !== exp_regs || {BUSY, ACK_A, ACK_B} !== 3'b000) begin
      errors++; $display("FAIL clr_applied got regs %h ctrl %b exp regs %h ctrl 000",
                         REGS, {BUSY, ACK_A, ACK_B}, exp_regs);
    end
    tick();
    REQ_B = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL clr_then_req busy got %b exp 1", BUSY); end
    tick();
    exp_regs[6*8 +: 8] = 8'h66;
    checks++;
    if (REGS !== exp_regs || {ACK_A, ACK_B} !== 2'b01) begin
      errors++; $display("FAIL clr_then_req_done got regs %h acks %b exp regs %h acks 01",
                         REGS, {ACK_A, ACK_B}, exp_regs);
    end
    tick();
  endtask

  task automatic test_addr_change();
    REQ_A = 1'b1; ADDR_A = 3'd0; DATA_A = 8'h01;
    tick();
    REQ_A = 1'b0; ADDR_A = 3'd5; DATA_A = 8'h77;
    tick();
    exp_regs[0 +: 8] = 8'h01;
    checks++;
    if (REGS !== exp_regs) begin errors++; $display("FAIL addr_hold got %h exp %h", REGS, exp_regs); end
    checks++;
    if (ACK_A !== 1'b1) begin errors++; $display("FAIL addr_hold_ack got %b exp 1", ACK_A); end
    tick();
  endtask

  task automatic test_reset_mid();
    REQ_B = 1'b1; ADDR_B = 3'd7; DATA_B = 8'hAB;
    tick();
    REQ_B = 1'b0;
    #2 nCLEAR = 1'b0;
    #1;
    exp_regs = '0;
    checks++;
    if (REGS !== exp_regs || {BUSY, ACK_A, ACK_B} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got regs %h ctrl %b exp regs %h ctrl 000",
                         REGS, {BUSY, ACK_A, ACK_B}, exp_regs);
    end
    #2 nCLEAR = 1'b1;
    tick();
    checks++;
    if (REGS !== exp_regs || {BUSY, ACK_A, ACK_B} !== 3'b000) begin
      errors++; $display("FAIL rst_abort got regs %h ctrl %b exp regs %h ctrl 000",
                         REGS, {BUSY, ACK_A, ACK_B}, exp_regs);
    end
    tick();
    checks++;
    if ({ACK_A, ACK_B} !== 2'b00) begin
      errors++; $display("FAIL rst_no_ack got %b exp 00", {ACK_A, ACK_B});
    end
    REQ_A = 1'b1; ADDR_A = 3'd2; DATA_A = 8'hC3;
    tick();
    REQ_A = 1'b0;
    tick();
    exp_regs[2*8 +: 8] = 8'hC3;
    checks++;
    if (REGS !== exp_regs || {ACK_A, ACK_B} !== 2'b10) begin
      errors++; $display("FAIL rst_recover got regs %h acks %b exp regs %h acks 10",
                         REGS, {ACK_A, ACK_B}, exp_regs);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_arbitration();
    test_clr_during_write();
    test_addr_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
